// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the I/D memory port arbiter.
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;
endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker: D-priority grant selection with a starvation counter that forces I after STARVE_LIMIT D wins.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic       grant_i,
  output arb_owner_t pick_o
);
  logic [3:0] starve_q, starve_d;
  assign pick_o = (i_req_i && (!d_req_i || starve_q == 4'(STARVE_LIMIT))) ? OWN_I : OWN_D;
  always_comb
    starve_d = !grant_i ? starve_q :
               pick_o == OWN_I ? 4'd0 :
               (i_req_i && starve_q != 4'hf) ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge clk)
    if (rst) starve_q <= 4'd0;
    else starve_q <= starve_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between I-cache and D-cache refills.
// Define MEM_ARB_PERF_EN to build the wait/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [MEM_ADDR_W-1:0] d_addr,
  input  logic [MEM_DATA_W-1:0] d_wdata,
  output logic                  i_gnt,
  output logic                  d_gnt,
  output logic                  i_beat,
  output logic                  d_beat,
  output logic                  i_done,
  output logic                  d_done,
  output logic [MEM_DATA_W-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_beat,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  proto_err,
  output logic [31:0]           perf_i_wait,
  output logic [31:0]           perf_d_wait,
  output logic [31:0]           perf_conflicts
);
  arb_state_t            state_q;
  arb_owner_t            owner_q, pick;
  logic [4:0]            beat_cnt_q;
  logic                  i_gnt_q, d_gnt_q, i_done_q, d_done_q;
  logic                  mem_req_q, mem_we_q, proto_err_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic                  grant_en, last_beat;

  assign grant_en  = state_q == IDLE && (i_req || d_req);
  assign last_beat = beat_cnt_q == 5'(BURST_LEN - 1);

  mem_arb_picker #(.STARVE_LIMIT(STARVE_LIMIT)) u_picker (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (i_req),
    .d_req_i (d_req),
    .grant_i (grant_en),
    .pick_o  (pick)
  );

  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_D;
      beat_cnt_q  <= 5'd0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      proto_err_q <= proto_err_q || (mem_beat && state_q != DATA);
      case (state_q)
        IDLE: if (grant_en) begin
          state_q    <= ADDR;
          owner_q    <= pick;
          i_gnt_q    <= pick == OWN_I;
          d_gnt_q    <= pick == OWN_D;
          mem_req_q  <= 1'b1;
          mem_we_q   <= pick == OWN_D && d_we;
          mem_addr_q <= pick == OWN_I ? i_addr : d_addr;
        end
        ADDR: if (mem_ack) begin
          state_q    <= DATA;
          beat_cnt_q <= 5'd0;
          mem_req_q  <= 1'b0;
          mem_addr_q <= '0;
        end
        DATA: if (mem_beat) begin
          beat_cnt_q <= beat_cnt_q + 5'd1;
          if (last_beat) begin
            state_q  <= DONE;
            mem_we_q <= 1'b0;
            i_done_q <= owner_q == OWN_I;
            d_done_q <= owner_q == OWN_D;
          end
        end
        DONE: begin
          state_q <= IDLE;
          i_gnt_q <= 1'b0;
          d_gnt_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_beat    = state_q == DATA && owner_q == OWN_I && mem_beat;
  assign d_beat    = state_q == DATA && owner_q == OWN_D && mem_beat;
  assign rdata     = mem_rdata;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = (d_gnt_q && d_we) ? d_wdata : '0;
  assign proto_err = proto_err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_c_q;
  always_ff @(posedge clk)
    if (rst) begin
      perf_i_q <= 32'd0;
      perf_d_q <= 32'd0;
      perf_c_q <= 32'd0;
    end else begin
      perf_i_q <= perf_i_q + 32'(i_req && !i_gnt_q);
      perf_d_q <= perf_d_q + 32'(d_req && !d_gnt_q);
      perf_c_q <= perf_c_q + 32'(state_q == IDLE && i_req && d_req);
    end
  assign perf_i_wait    = perf_i_q;
  assign perf_d_wait    = perf_d_q;
  assign perf_conflicts = perf_c_q;
`else
  assign perf_i_wait    = 32'd0;
  assign perf_d_wait    = 32'd0;
  assign perf_conflicts = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level reference model with per-cycle compare, directed and random stimulus.
module tb_mem_port_arbiter;
  localparam int BL = 4;
  localparam int SL = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        mem_ack = 1'b0, mem_beat = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        i_gnt, d_gnt, i_beat, d_beat, i_done, d_done, mem_req, mem_we, proto_err;
  logic [31:0] rdata, mem_addr, mem_wdata, perf_i_wait, perf_d_wait, perf_conflicts;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BURST_LEN(BL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_gnt(i_gnt), .d_gnt(d_gnt), .i_beat(i_beat),
    .d_beat(d_beat), .i_done(i_done), .d_done(d_done), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_beat(mem_beat), .mem_rdata(mem_rdata), .proto_err(proto_err),
    .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait), .perf_conflicts(perf_conflicts)
  );

  int total = 0, bad = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one burst in flight, described by owner, ack seen and beats counted.
  logic        m_busy = 0, m_own_i = 0, m_acked = 0, m_we = 0, m_perr = 0;
  int          m_beats = 0, m_starve = 0, m_ndone = 0, m_ni = 0, m_nd = 0;
  logic [31:0] m_addr = '0, m_pi = '0, m_pd = '0, m_pc = '0;
  logic        ap, dp, np, pick_i, e_ig, e_dg;
  assign ap     = m_busy && !m_acked;
  assign dp     = m_busy && m_acked && m_beats < BL;
  assign np     = m_busy && m_acked && m_beats == BL;
  assign e_ig   = m_busy && m_own_i;
  assign e_dg   = m_busy && !m_own_i;
  assign pick_i = i_req && (!d_req || m_starve == SL);

  always @(posedge clk)
    if (rst) begin
      m_busy <= 0; m_own_i <= 0; m_acked <= 0; m_we <= 0; m_perr <= 0;
      m_beats <= 0; m_starve <= 0; m_addr <= '0; m_pi <= '0; m_pd <= '0; m_pc <= '0;
    end else begin
      m_pi <= m_pi + 32'(i_req && !e_ig);
      m_pd <= m_pd + 32'(d_req && !e_dg);
      m_pc <= m_pc + 32'(!m_busy && i_req && d_req);
      if (mem_beat && !dp) m_perr <= 1;
      if (!m_busy) begin
        if (i_req || d_req) begin
          m_busy   <= 1; m_acked <= 0; m_beats <= 0;
          m_own_i  <= pick_i;
          m_we     <= !pick_i && d_we;
          m_addr   <= pick_i ? i_addr : d_addr;
          m_starve <= pick_i ? 0 : (i_req && m_starve < 15) ? m_starve + 1 : m_starve;
        end
      end else if (!m_acked) m_acked <= mem_ack;
      else if (m_beats < BL) m_beats <= m_beats + int'(mem_beat);
      else begin
        m_busy  <= 0;
        m_ndone <= m_ndone + 1;
        if (m_own_i) m_ni <= m_ni + 1;
        else m_nd <= m_nd + 1;
      end
    end

  // Per-cycle compare plus logs of DUT-visible events for the directed checks.
  bit          glog[$];
  logic [31:0] wlog[$];
  logic        prev_g = 0;
  int          cnt_ib = 0, cnt_id = 0, cnt_dany = 0, cnt_dd = 0, cnt_wwe = 0;
  always @(negedge clk)
    if (!rst) begin
      check("i_gnt", 32'(i_gnt), 32'(e_ig));
      check("d_gnt", 32'(d_gnt), 32'(e_dg));
      check("i_beat", 32'(i_beat), 32'(dp && m_own_i && mem_beat));
      check("d_beat", 32'(d_beat), 32'(dp && !m_own_i && mem_beat));
      check("i_done", 32'(i_done), 32'(np && m_own_i));
      check("d_done", 32'(d_done), 32'(np && !m_own_i));
      check("mem_req", 32'(mem_req), 32'(ap));
      check("mem_we", 32'(mem_we), 32'((ap || dp) && m_we));
      check("mem_addr", mem_addr, ap ? m_addr : 32'd0);
      check("mem_wdata", mem_wdata, (e_dg && d_we) ? d_wdata : 32'd0);
      check("rdata", rdata, mem_rdata);
      check("proto_err", 32'(proto_err), 32'(m_perr));
`ifdef MEM_ARB_PERF_EN
      check("perf_i_wait", perf_i_wait, m_pi);
      check("perf_d_wait", perf_d_wait, m_pd);
      check("perf_conflicts", perf_conflicts, m_pc);
`else
      check("perf_off", perf_i_wait | perf_d_wait | perf_conflicts, 32'd0);
`endif
      prev_g <= i_gnt | d_gnt;
      if ((i_gnt | d_gnt) && !prev_g) glog.push_back(i_gnt);
      if (d_beat) wlog.push_back(mem_wdata);
      cnt_ib   <= cnt_ib + int'(i_beat);
      cnt_id   <= cnt_id + int'(i_done);
      cnt_dd   <= cnt_dd + int'(d_done);
      cnt_dany <= cnt_dany + int'(d_gnt | d_beat | d_done);
      cnt_wwe  <= cnt_wwe + int'(d_beat && mem_we);
    end

  // Memory responder: 0 random, 1 ack after ack_dly ADDR cycles then a beat every cycle, 2 driven by the main block.
  int mode = 2, ack_dly = 0;
  initial begin
    int ack_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = $urandom;
      if (mode == 0) begin
        mem_ack  = ($urandom_range(2) == 0);
        mem_beat = dp && ($urandom_range(1) == 1);
      end else if (mode == 1) begin
        mem_ack  = ap && ack_cnt >= ack_dly;
        mem_beat = dp;
        ack_cnt  = ap ? ack_cnt + 1 : 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int n0);
    int n = 0;
    while (m_ndone == n0 && n < 200) begin
      tick();
      n++;
    end
    check("burst_done", 32'(m_ndone != n0), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(m_busy), 32'd0);
  endtask

  task automatic pulse_rst();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    int n0, g0, w0, ib0, id0, dd0, da0, we0, n, iseen, dseen;
    bit gexp[8];
    repeat (3) tick();
    @(negedge clk);
    check("rst_ctrl", 32'({i_gnt, d_gnt, i_beat, d_beat, i_done, d_done, mem_req, mem_we, proto_err}), 32'd0);
    check("rst_addr", mem_addr | mem_wdata, 32'd0);
    check("rst_perf", perf_i_wait | perf_d_wait | perf_conflicts, 32'd0);
    tick();
    rst = 0;

    // Both requesters held: D wins until the starvation limit forces I.
    mode = 1; ack_dly = 0;
    g0 = glog.size();
    i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h2000; d_we = 0;
    n = 0;
    while (glog.size() < g0 + 8 && n < 400) begin
      tick();
      n++;
    end
    i_req = 0; d_req = 0;
    wait_idle();
    check("grant_count", 32'(glog.size() >= g0 + 8), 32'd1);
    gexp = '{0, 0, 0, 1, 0, 0, 0, 1};
    if (glog.size() >= g0 + 8)
      for (int k = 0; k < 8; k++) check($sformatf("grant_order[%0d]", k), 32'(glog[g0 + k]), 32'(gexp[k]));

    // D write burst with data advancing on each consumed beat.
    w0 = wlog.size(); we0 = cnt_wwe; n0 = m_ndone;
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'hA0;
    n = 0;
    while (m_ndone == n0 && n < 200) begin
      tick();
      d_wdata = 32'hA0 + 32'(m_beats);
      n++;
    end
    d_req = 0; d_we = 0;
    check("write_done", 32'(m_ndone != n0), 32'd1);
    check("write_beats", 32'(wlog.size() - w0), 32'd4);
    if (wlog.size() >= w0 + 4)
      for (int k = 0; k < 4; k++) check($sformatf("wdata[%0d]", k), wlog[w0 + k], 32'hA0 + 32'(k));
    @(negedge clk);
    check("write_we_beats", 32'(cnt_wwe - we0), 32'd4);
    tick();

    // Stray beat while idle: sticky error, no requester pulses, cleared only by reset.
    mode = 2; mem_ack = 0; mem_beat = 1;
    @(negedge clk);
    check("stray_no_beat", 32'({i_beat, d_beat, i_done, d_done}), 32'd0);
    tick();
    mem_beat = 0;
    repeat (3) tick();
    @(negedge clk);
    check("proto_err_sticky", 32'(proto_err), 32'd1);
    tick();
    pulse_rst();
    @(negedge clk);
    check("proto_err_cleared", 32'(proto_err), 32'd0);

    // Reset in the middle of a D read burst: abort without done.
    mode = 1; ack_dly = 0;
    dd0 = cnt_dd;
    d_req = 1; d_addr = 32'h5000; d_we = 0;
    n = 0;
    while (!(dp && m_beats == 2) && n < 50) begin
      tick();
      n++;
    end
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    @(negedge clk);
    check("abort_ctrl", 32'({i_gnt, d_gnt, i_beat, d_beat, i_done, d_done, mem_req, mem_we}), 32'd0);
    check("abort_addr", mem_addr | mem_wdata, 32'd0);
    tick();
    tick();
    check("abort_no_done", 32'(cnt_dd - dd0), 32'd0);

    // Lone I request, memory acks after two ADDR cycles.
    ack_dly = 2;
    ib0 = cnt_ib; id0 = cnt_id; da0 = cnt_dany; n0 = m_ndone;
    i_req = 1; i_addr = 32'h4000;
    @(negedge clk);
    check("lone_gnt_t", 32'(i_gnt), 32'd0);
    tick();
    @(negedge clk);
    check("lone_gnt_t1", 32'({i_gnt, mem_req}), 32'd3);
    check("lone_addr", mem_addr, 32'h4000);
    wait_done(n0);
    i_req = 0;
    tick();
    check("lone_i_beats", 32'(cnt_ib - ib0), 32'd4);
    check("lone_i_done", 32'(cnt_id - id0), 32'd1);
    check("lone_d_silent", 32'(cnt_dany - da0), 32'd0);

    // One-cycle conflict followed by a six-cycle D burst.
    pulse_rst();
    ack_dly = 0; n0 = m_ndone;
    i_req = 1; d_req = 1; i_addr = 32'h6000; d_addr = 32'h7000;
    wait_done(n0);
    i_req = 0; d_req = 0;
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check("perf_conflicts_lit", perf_conflicts, 32'd1);
    check("perf_i_wait_lit", perf_i_wait, 32'd7);
    check("perf_d_wait_lit", perf_d_wait, 32'd1);
`else
    check("perf_tied_lit", perf_i_wait | perf_d_wait | perf_conflicts, 32'd0);
`endif
    tick();

    // Random traffic against the model.
    pulse_rst();
    mode = 0; iseen = m_ni; dseen = m_nd;
    for (int c = 0; c < 3000; c++) begin
      tick();
      d_wdata = $urandom;
      if (!i_req) begin
        if ($urandom_range(3) == 0) begin i_req = 1; i_addr = $urandom; end
      end else if (m_ni != iseen) begin
        iseen = m_ni;
        if ($urandom_range(1) == 1) i_req = 0; else i_addr = $urandom;
      end else if ($urandom_range(63) == 0) i_req = 0;
      if (!d_req) begin
        if ($urandom_range(3) == 0) begin d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(1)); end
      end else if (m_nd != dseen) begin
        dseen = m_nd;
        if ($urandom_range(1) == 1) d_req = 0; else d_addr = $urandom;
      end else if ($urandom_range(63) == 0) d_req = 0;
    end
    i_req = 0; d_req = 0;
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
